// File: rtl/serial_capture_pkg.sv
// Shared types and limits for the serial_capture block.
// Holds the FSM state enum, bit-counter width and the WIDTH ceiling.
package serial_capture_pkg;

  localparam int CNT_W     = 7;
  localparam int MAX_WIDTH = 127;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/serial_capture_ctl.sv
// Frame-sequencing FSM and bit counter for serial_capture.
// Ports: clk, rst_n, frame in; start_o (MSB sample), shift_o (data bit
// sample), done_o (final frame bit sampled), drop_o (frame lost mid-word).
// With SERIAL_CAPTURE_PARITY_EN the frame carries one extra parity bit.
module serial_capture_ctl
  import serial_capture_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame,
  output logic start_o,
  output logic shift_o,
  output logic done_o,
  output logic drop_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    start_o  = 1'b0;
    shift_o  = 1'b0;
    done_o   = 1'b0;
    drop_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame) begin
          start_o  = 1'b1;
          bitcnt_d = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!frame) begin
          drop_o   = 1'b1;
          bitcnt_d = '0;
          state_d  = IDLE;
        end else begin
          shift_o = 1'b1;
          if (bitcnt_q == LAST) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
            bitcnt_d = bitcnt_q + CNT_W'(1);
            state_d  = PARITY;
`else
            done_o   = 1'b1;
            bitcnt_d = '0;
            state_d  = IDLE;
`endif
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SERIAL_CAPTURE_PARITY_EN
      PARITY: begin
        bitcnt_d = '0;
        state_d  = IDLE;
        if (!frame) begin
          drop_o = 1'b1;
        end else begin
          done_o = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/serial_capture.sv
// Serial-to-parallel word capture, MSB first, with ack/overrun handling.
// Ports: clk, rst_n, sin, frame, dout_ack in; dout, dout_valid,
// frame_err, overrun, par_err out. Macro SERIAL_CAPTURE_PARITY_EN
// adds a trailing even-parity bit per word; otherwise par_err is 0.
module serial_capture
  import serial_capture_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             frame,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ack,
  output logic             frame_err,
  output logic             overrun,
  output logic             par_err
);

  // Without parity the last data bit goes straight from sin into dout,
  // so only WIDTH-1 bits need to be held.
`ifdef SERIAL_CAPTURE_PARITY_EN
  localparam int SW = WIDTH;
`else
  localparam int SW = WIDTH - 1;
`endif

  logic             start, shift, done, drop;
  logic             cmp;
  logic [WIDTH-1:0] word;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  serial_capture_ctl #(
    .WIDTH(WIDTH)
  ) u_ctl (
    .clk    (clk),
    .rst_n  (rst_n),
    .frame  (frame),
    .start_o(start),
    .shift_o(shift),
    .done_o (done),
    .drop_o (drop)
  );

`ifdef SERIAL_CAPTURE_PARITY_EN
  logic par_q, par_d;
  logic par_err_q, par_err_d;
  logic par_ok;

  always_comb begin
    par_d = par_q;
    if (start) begin
      par_d = sin;
    end else if (shift) begin
      par_d = par_q ^ sin;
    end
    // Even parity: data xor parity bit must be zero.
    par_ok    = ~(par_q ^ sin);
    word      = sreg_q;
    cmp       = done & par_ok;
    par_err_d = done & ~par_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  always_comb begin
    word = {sreg_q, sin};
    cmp  = done;
  end

  assign par_err = 1'b0;
`endif

  always_comb begin
    sreg_d = sreg_q;
    if (start) begin
      sreg_d = SW'(sin);
    end else if (shift) begin
      sreg_d = SW'({sreg_q, sin});
    end
  end

  // A completing word wins over ack; ack then only suppresses overrun.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    frame_err_d  = drop;
    if (cmp) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
      overrun_d    = dout_valid_q & ~dout_ack;
    end else if (dout_ack) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_capture.sv
// Self-checking bench for serial_capture at WIDTH=8.
// Vector table, directed corner sequences and random traffic vs a model.
module tb_serial_capture;

  localparam int WIDTH = 8;
`ifdef SERIAL_CAPTURE_PARITY_EN
  localparam int FL  = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             sin = 1'b0;
  logic             frame = 1'b0;
  logic             dout_ack = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             frame_err;
  logic             overrun;
  logic             par_err;

  always #5 clk = ~clk;

  serial_capture #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .frame     (frame),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ack  (dout_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .par_err   (par_err)
  );

  int    checks = 0;
  int    failures = 0;
  string phase = "init";

  bit               mq[$];
  logic [WIDTH-1:0] m_dout;
  bit               m_valid, m_ferr, m_ovr, m_perr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s actual=%0h required=%0h", phase, name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endfunction

  // Word-level model: collect frame bits in a queue, act when it is full.
  function automatic void model_step(bit f, bit s, bit a);
    bit               v0 = m_valid;
    bit               good = 1'b0;
    bit               p = 1'b0;
    logic [WIDTH-1:0] w = '0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
    if (!f) begin
      if (mq.size() != 0) begin
        m_ferr = 1'b1;
        mq.delete();
      end
    end else begin
      mq.push_back(s);
      if (mq.size() == FL) begin
        for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], mq[i]};
        foreach (mq[i]) p ^= mq[i];
        good = PAR ? (p == 1'b0) : 1'b1;
        m_perr = !good;
        mq.delete();
      end
    end
    if (good) begin
      m_ovr   = v0 && !a;
      m_dout  = w;
      m_valid = 1'b1;
    end else if (a) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic check_outs();
    chk("dout", dout, m_dout);
    chk("dout_valid", dout_valid, m_valid);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    chk("par_err", par_err, m_perr);
  endtask

  task automatic cyc(input bit f, input bit s, input bit a);
    frame    = f;
    sin      = s;
    dout_ack = a;
    @(posedge clk);
    model_step(f, s, a);
    #1;
    check_outs();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit pgood,
                           input bit ack_last);
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
      cyc(1'b1, w[i], 1'b0);
`else
      cyc(1'b1, w[i], (i == 0) ? ack_last : 1'b0);
`endif
    end
`ifdef SERIAL_CAPTURE_PARITY_EN
    cyc(1'b1, (^w) ^ !pgood, ack_last);
`else
    if (pgood) begin
    end
`endif
  endtask

  typedef struct {
    bit               f;
    bit               s;
    bit               a;
    logic [WIDTH-1:0] e_dout;
    bit               e_valid;
    bit               e_ferr;
    bit               e_ovr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    chk("rst_dout", dout, 0);
    @(negedge clk) rst_n = 1'b1;
    phase = "idle";
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);

`ifndef SERIAL_CAPTURE_PARITY_EN
    tbl[0] = '{1, 1, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 8'h00, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[4] = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[5] = '{1, 1, 0, 8'h00, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 8'h00, 0, 0, 0};
    tbl[7] = '{1, 1, 0, 8'hA5, 1, 0, 0};
    tbl[8] = '{0, 0, 1, 8'hA5, 0, 0, 0};
    tbl[9] = '{0, 1, 0, 8'hA5, 0, 0, 0};
    phase = "tbl_a5";
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].f, tbl[i].s, tbl[i].a);
      chk("t_dout", dout, tbl[i].e_dout);
      chk("t_valid", dout_valid, tbl[i].e_valid);
      chk("t_ferr", frame_err, tbl[i].e_ferr);
      chk("t_ovr", overrun, tbl[i].e_ovr);
    end
`else
    phase = "par_a5";
    send_word(8'hA5, 1'b1, 1'b0);
    chk("p_dout", dout, 8'hA5);
    chk("p_valid", dout_valid, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("p_ack", dout_valid, 0);
    send_word(8'hA5, 1'b0, 1'b0);
    chk("p_perr", par_err, 1);
    chk("p_valid_bad", dout_valid, 0);
    chk("p_ovr_bad", overrun, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("p_perr_end", par_err, 0);
    send_word(8'h3C, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
`endif

    phase = "b2b";
    send_word(8'h3C, 1'b1, 1'b0);
    chk("b2b_first", dout, 8'h3C);
    send_word(8'hC3, 1'b1, 1'b0);
    chk("b2b_dout", dout, 8'hC3);
    chk("b2b_ovr", overrun, 1);
    chk("b2b_valid", dout_valid, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("b2b_ovr_end", overrun, 0);

    phase = "drop";
    for (int i = 0; i < 5; i++) cyc(1'b1, i[0], 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("drop_ferr", frame_err, 1);
    chk("drop_valid", dout_valid, 1);
    chk("drop_dout", dout, 8'hC3);
    cyc(1'b0, 1'b0, 1'b0);
    chk("drop_ferr_end", frame_err, 0);
    send_word(8'h01, 1'b1, 1'b0);
    chk("after_drop", dout, 8'h01);

    phase = "midrst";
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_dout", dout, 0);
    chk("ar_valid", dout_valid, 0);
    frame = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    send_word(8'hFF, 1'b1, 1'b0);
    chk("rst_ff", dout, 8'hFF);
    chk("rst_valid", dout_valid, 1);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);

    phase = "ack_cmp";
    send_word(8'h5A, 1'b1, 1'b1);
    chk("ac_dout", dout, 8'h5A);
    chk("ac_valid", dout_valid, 1);
    chk("ac_ovr", overrun, 0);

    phase = "random";
    repeat (3000) begin
      cyc($urandom_range(0, 99) < 90, 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
